// File: rtl/game_sequencer.sv
// game_sequencer: phase sequencer, game_tik generator, turn buffer and score
// keeper sitting between vga_tracker and the snake FSM.
// Optional feature: define PAUSE_EN to enable PLAY<->PAUSE toggling via a
// rising edge on both buttons held together.
module game_sequencer #(
  parameter int unsigned FRAMES_PER_TIK_INIT = 15,
  parameter int unsigned FRAMES_PER_TIK_MIN  = 4,
  parameter int unsigned SPEEDUP_EVERY       = 4,
  parameter int unsigned SCORE_W             = 8
) (
  input  logic               clock_25,
  input  logic               reset,
  input  logic               frame_tik,
  input  logic               right_P,
  input  logic               left_P,
  input  logic               fruit_eaten,
  input  logic               collision,
  output logic               game_tik,
  output logic               turn_right,
  output logic               turn_left,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         game_state,
  output logic [3:0]         frames_per_tik
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_OVER  = 2'b10,
    ST_PAUSE = 2'b11
  } state_e;

  localparam logic [3:0]         PER_INIT = 4'(FRAMES_PER_TIK_INIT);
  localparam logic [3:0]         PER_MIN  = 4'(FRAMES_PER_TIK_MIN);
  localparam logic [SCORE_W-1:0] SPD_MASK = SCORE_W'(SPEEDUP_EVERY - 1);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         fpt_q, fpt_d;   // announced period, changed by speedups
  logic [3:0]         act_q, act_d;   // period of the running count
  logic [3:0]         cnt_q, cnt_d;
  logic               tik_q, tik_d;
  logic               pend_r_q, pend_r_d;
  logic               pend_l_q, pend_l_d;

  logic [1:0] r_sync_q, l_sync_q;
  logic       r_prev_q, l_prev_q, both_prev_q;

  logic press_r, press_l, both_rise, pr, pl, any_press;

  // Button synchronizers and edge-detect history
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      r_sync_q    <= '0;
      l_sync_q    <= '0;
      r_prev_q    <= 1'b0;
      l_prev_q    <= 1'b0;
      both_prev_q <= 1'b0;
    end else begin
      r_sync_q    <= {r_sync_q[0], right_P};
      l_sync_q    <= {l_sync_q[0], left_P};
      r_prev_q    <= r_sync_q[1];
      l_prev_q    <= l_sync_q[1];
      both_prev_q <= r_sync_q[1] & l_sync_q[1];
    end
  end

  // Press decode; a both-buttons edge suppresses single presses in that cycle
  always_comb begin
    press_r   = r_sync_q[1] & ~r_prev_q;
    press_l   = l_sync_q[1] & ~l_prev_q;
    both_rise = r_sync_q[1] & l_sync_q[1] & ~both_prev_q;
    pr        = press_r & ~both_rise;
    pl        = press_l & ~both_rise;
    any_press = pr | pl;
  end

  // State, score, period, counter and turn-buffer registers
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      score_q  <= '0;
      fpt_q    <= PER_INIT;
      act_q    <= PER_INIT;
      cnt_q    <= '0;
      tik_q    <= 1'b0;
      pend_r_q <= 1'b0;
      pend_l_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      fpt_q    <= fpt_d;
      act_q    <= act_d;
      cnt_q    <= cnt_d;
      tik_q    <= tik_d;
      pend_r_q <= pend_r_d;
      pend_l_q <= pend_l_d;
    end
  end

  // Next-state logic for phases, tik generation, scoring and turn capture
  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    fpt_d    = fpt_q;
    act_d    = act_q;
    cnt_d    = cnt_q;
    tik_d    = 1'b0;
    pend_r_d = 1'b0;
    pend_l_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_press) begin
          state_d = ST_PLAY;
          score_d = '0;
          fpt_d   = PER_INIT;
          act_d   = PER_INIT;
          cnt_d   = '0;
        end
      end
      ST_PLAY: begin
        // Entry is free again in the tik cycle, so a press there opens the next period
        if (tik_q || !(pend_r_q || pend_l_q)) begin
          pend_r_d = pr;
          pend_l_d = pl;
        end else begin
          pend_r_d = pend_r_q;
          pend_l_d = pend_l_q;
        end
        // Speedups only land in fpt; the running count keeps act until it wraps
        if (frame_tik) begin
          if (cnt_q == 4'(act_q - 4'd1)) begin
            cnt_d = '0;
            act_d = fpt_q;
            tik_d = 1'b1;
          end else begin
            cnt_d = 4'(cnt_q + 4'd1);
          end
        end
        if (fruit_eaten && (score_q != '1)) begin
          score_d = SCORE_W'(score_q + 1'b1);
          if (((score_d & SPD_MASK) == '0) && (fpt_q > PER_MIN))
            fpt_d = 4'(fpt_q - 4'd1);
        end
        if (collision) begin
          state_d = ST_OVER;
          tik_d   = 1'b0;
        end
`ifdef PAUSE_EN
        else if (both_rise) begin
          state_d  = ST_PAUSE;
          tik_d    = 1'b0;
          cnt_d    = cnt_q;
          act_d    = act_q;
          pend_r_d = 1'b0;
          pend_l_d = 1'b0;
        end
`endif
      end
      ST_OVER: begin
        if (any_press) state_d = ST_IDLE;
      end
`ifdef PAUSE_EN
      ST_PAUSE: begin
        if (both_rise) state_d = ST_PLAY;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign game_tik       = tik_q;
  assign turn_right     = tik_q & pend_r_q;
  assign turn_left      = tik_q & pend_l_q;
  assign score          = score_q;
  assign game_state     = state_q;
  assign frames_per_tik = fpt_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: a table of phase/score vectors followed
// by hand-written multi-cycle sequences for tik timing, turns and pause.
module tb_game_sequencer;

  logic       clock_25 = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tik = 1'b0;
  logic       right_P = 1'b0;
  logic       left_P = 1'b0;
  logic       fruit_eaten = 1'b0;
  logic       collision = 1'b0;
  logic       game_tik, turn_right, turn_left;
  logic [7:0] score;
  logic [1:0] game_state;
  logic [3:0] frames_per_tik;

  game_sequencer #(
    .FRAMES_PER_TIK_INIT(15),
    .FRAMES_PER_TIK_MIN (4),
    .SPEEDUP_EVERY      (4),
    .SCORE_W            (8)
  ) dut (
    .clock_25      (clock_25),
    .reset         (reset),
    .frame_tik     (frame_tik),
    .right_P       (right_P),
    .left_P        (left_P),
    .fruit_eaten   (fruit_eaten),
    .collision     (collision),
    .game_tik      (game_tik),
    .turn_right    (turn_right),
    .turn_left     (turn_left),
    .score         (score),
    .game_state    (game_state),
    .frames_per_tik(frames_per_tik)
  );

  always #20 clock_25 = ~clock_25;

  int n_vec = 0;
  int n_bad = 0;

  int       frame_cnt = 0;
  int       tik_cnt = 0;
  int       stray = 0;
  logic [1:0] last_turn = 2'b00;

  // Observe outputs mid-cycle, away from the active edge
  always @(negedge clock_25) begin
    if (frame_tik) frame_cnt++;
    if (game_tik) begin
      tik_cnt++;
      last_turn = {turn_right, turn_left};
    end
    if ((turn_right | turn_left) & ~game_tik) stray++;
  end

  localparam int OP_PRESS_R   = 0;
  localparam int OP_PRESS_L   = 1;
  localparam int OP_PRESS_B   = 2;
  localparam int OP_FRUIT     = 3;
  localparam int OP_COLL      = 4;
  localparam int OP_FRUITCOLL = 5;

  typedef struct {
    int op;
    int n;
    int exp_state;
    int exp_score;
    int exp_fpt;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clock_25);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic r, input logic l);
    right_P = r;
    left_P  = l;
    repeat (4) tick();
    right_P = 1'b0;
    left_P  = 1'b0;
    repeat (4) tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tik = 1'b1;
      tick();
      frame_tik = 1'b0;
      repeat (3) tick();
    end
  endtask

  task automatic fruits(input int n);
    for (int i = 0; i < n; i++) begin
      fruit_eaten = 1'b1;
      tick();
      fruit_eaten = 1'b0;
      tick();
    end
  endtask

  task automatic pulse(input logic f, input logic c);
    fruit_eaten = f;
    collision   = c;
    tick();
    fruit_eaten = 1'b0;
    collision   = 1'b0;
    repeat (2) tick();
  endtask

  // Frames fed until the next game_tik appears; -1 if none within maxf
  task automatic frames_until_tik(input int maxf, output int n);
    int t0;
    t0 = tik_cnt;
    n  = 0;
    while ((tik_cnt == t0) && (n < maxf)) begin
      frames(1);
      n++;
    end
    if (tik_cnt == t0) n = -1;
  endtask

  task automatic chk_phase(input string name, input int st, input int sc, input int fp);
    chk({name, ".state"}, int'(game_state), st);
    chk({name, ".score"}, int'(score), sc);
    chk({name, ".fpt"}, int'(frames_per_tik), fp);
  endtask

  initial begin
    int n, t0;

    vecs[0]  = '{OP_PRESS_R,   1,   1,   0, 15};
    vecs[1]  = '{OP_FRUIT,     3,   1,   3, 15};
    vecs[2]  = '{OP_FRUIT,     1,   1,   4, 14};
    vecs[3]  = '{OP_FRUIT,     3,   1,   7, 14};
    vecs[4]  = '{OP_FRUITCOLL, 1,   2,   8, 13};
    vecs[5]  = '{OP_FRUIT,     2,   2,   8, 13};
    vecs[6]  = '{OP_COLL,      1,   2,   8, 13};
    vecs[7]  = '{OP_PRESS_L,   1,   0,   8, 13};
    vecs[8]  = '{OP_PRESS_R,   1,   1,   0, 15};
    vecs[9]  = '{OP_FRUIT,   300,   1, 255,  4};
    vecs[10] = '{OP_COLL,      1,   2, 255,  4};
    vecs[11] = '{OP_PRESS_R,   1,   0, 255,  4};
    vecs[12] = '{OP_PRESS_B,   1,   0, 255,  4};
    vecs[13] = '{OP_PRESS_L,   1,   1,   0, 15};

    repeat (3) tick();
    chk_phase("reset", 0, 0, 15);
    chk("reset.tik", int'(game_tik), 0);
    reset = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 14; i++) begin
      case (vecs[i].op)
        OP_PRESS_R:   press(1'b1, 1'b0);
        OP_PRESS_L:   press(1'b0, 1'b1);
        OP_PRESS_B:   press(1'b1, 1'b1);
        OP_FRUIT:     fruits(vecs[i].n);
        OP_COLL:      pulse(1'b0, 1'b1);
        default:      pulse(1'b1, 1'b1);
      endcase
      chk_phase($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_score, vecs[i].exp_fpt);
    end

    // Asynchronous reset mid-play, then a clean start
    frames(5);
    fruits(2);
    press(1'b1, 1'b0);
    reset = 1'b0;
    #1;
    chk_phase("midreset", 0, 0, 15);
    chk("midreset.tik", int'(game_tik), 0);
    tick();
    reset = 1'b1;
    repeat (2) tick();
    chk("after_reset.state", int'(game_state), 0);
    press(1'b1, 1'b0);
    chk_phase("restart", 1, 0, 15);
    frames_until_tik(40, n);
    chk("first_tik.frames", n, 15);
    chk("first_tik.turn", int'(last_turn), 0);

    // Single-entry turn buffer: first press wins, cleared after its tik
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    frames_until_tik(40, n);
    chk("turn_tik.frames", n, 15);
    chk("turn_tik.turn", int'(last_turn), 1);
    frames_until_tik(40, n);
    chk("noturn_tik.frames", n, 15);
    chk("noturn_tik.turn", int'(last_turn), 0);

    // Speedup lands at the next wrap without shortening the running count
    frames(5);
    fruits(4);
    chk_phase("speedup", 1, 4, 14);
    frames_until_tik(40, n);
    chk("speedup.old_period", n, 10);
    frames_until_tik(40, n);
    chk("speedup.new_period", n, 14);

    // Fruit and collision together, then OVER -> IDLE -> PLAY
    fruits(3);
    chk("pre_over.score", int'(score), 7);
    pulse(1'b1, 1'b1);
    chk_phase("over", 2, 8, 13);
    t0 = tik_cnt;
    frames(50);
    chk("over.tiks", tik_cnt - t0, 0);
    chk("over.score_frozen", int'(score), 8);
    press(1'b1, 1'b0);
    chk("over_press.state", int'(game_state), 0);
    press(1'b0, 1'b1);
    chk_phase("replay", 1, 0, 15);

    // Both buttons: pause toggle when enabled, ignored otherwise
    frames(3);
    press(1'b1, 1'b1);
`ifdef PAUSE_EN
    chk("both1.state", int'(game_state), 3);
`else
    chk("both1.state", int'(game_state), 1);
`endif
    t0 = tik_cnt;
    frames(40);
`ifdef PAUSE_EN
    chk("both1.tiks", tik_cnt - t0, 0);
`else
    chk("both1.tiks", tik_cnt - t0, 2);
`endif
    press(1'b1, 1'b1);
    chk("both2.state", int'(game_state), 1);
    frames_until_tik(40, n);
`ifdef PAUSE_EN
    chk("both2.frames", n, 12);
`else
    chk("both2.frames", n, 2);
`endif
    chk("both2.turn", int'(last_turn), 0);

    chk("stray_turn", stray, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
